// File: rtl/pipe_cpu_boot_ctrl.sv
// pipe_cpu_boot_ctrl
//   Boot and run controller that sits between a pipelined CPU core and its
//   instruction memory. It streams a program image into memory, then releases
//   CPU reset, pulses start, and runs the CPU for a cycle budget or until it is
//   halted. After the run the CPU is frozen so its state stays observable.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | CPU held in reset, waiting for load_req
//   LOAD  | accepting image words into instruction memory
//   START | one cycle: latch run_limit, clear cycle_cnt, pulse cpu_start
//   RUN   | CPU enabled, cycle_cnt counting
//   DONE  | CPU frozen (out of reset, clock disabled), results held
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   load_req              : start a new image load (IDLE/DONE only)
//   ld_valid/ld_data/ld_last, ld_ready : image word stream
//   run_limit             : RUN budget in cycles, 0 = unlimited
//   halt_req              : stop the CPU (RUN only)
//   cpu_i_addr            : CPU fetch address
//   im_addr/im_we/im_din  : instruction memory port
//   cpu_reset/cpu_start/cpu_enable : CPU controls
//   state, load_cnt, cycle_cnt, ld_err : status
module pipe_cpu_boot_ctrl #(
  parameter int DATA_W   = 16,
  parameter int I_ADDR_W = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_req,
  input  logic                ld_valid,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic                ld_last,
  output logic                ld_ready,
  input  logic [CNT_W-1:0]    run_limit,
  input  logic                halt_req,
  input  logic [I_ADDR_W-1:0] cpu_i_addr,
  output logic [I_ADDR_W-1:0] im_addr,
  output logic                im_we,
  output logic [DATA_W-1:0]   im_din,
  output logic                cpu_reset,
  output logic                cpu_start,
  output logic                cpu_enable,
  output logic [2:0]          state,
  output logic [I_ADDR_W:0]   load_cnt,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic                ld_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [I_ADDR_W-1:0] PTR_ONE = {{(I_ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [I_ADDR_W:0]   LDC_ONE = {{I_ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_q;
  logic [I_ADDR_W-1:0] ptr_q;
  logic [CNT_W-1:0]    limit_q;
  logic                accept;
  logic                limit_hit;

  assign accept    = ld_valid & ld_ready;
  // Compare against limit-1 so the exit cycle itself is the L-th RUN cycle.
  assign limit_hit = (limit_q != '0) && (cycle_cnt == (limit_q - CNT_ONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      load_cnt  <= '0;
      cycle_cnt <= '0;
      ld_err    <= 1'b0;
      limit_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (load_req) begin
            state_q  <= S_LOAD;
            ptr_q    <= '0;
            load_cnt <= '0;
            ld_err   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            ptr_q    <= ptr_q + PTR_ONE;
            load_cnt <= load_cnt + LDC_ONE;
            if (ld_last) begin
              state_q <= S_START;
            end else if (ptr_q == '1) begin
              // Image does not fit: last slot was written, abandon the load.
              ld_err  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        S_START: begin
          limit_q   <= run_limit;
          cycle_cnt <= '0;
          state_q   <= S_RUN;
        end
        S_RUN: begin
          if (cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
          end
          if (halt_req || limit_hit) begin
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_reset  = 1'b0;
    cpu_start  = 1'b0;
    cpu_enable = 1'b0;
    ld_ready   = 1'b0;
    im_addr    = cpu_i_addr;
    case (state_q)
      S_IDLE: begin
        cpu_reset = 1'b1;
        im_addr   = ptr_q;
      end
      S_LOAD: begin
        cpu_reset = 1'b1;
        ld_ready  = 1'b1;
        im_addr   = ptr_q;
      end
      S_START: begin
        cpu_start  = 1'b1;
        cpu_enable = 1'b1;
      end
      S_RUN:   cpu_enable = 1'b1;
      default: ;
    endcase
  end

  assign im_we  = accept;
  assign im_din = ld_data;
  assign state  = state_q;

endmodule

// File: tb/tb_pipe_cpu_boot_ctrl.sv
module tb_pipe_cpu_boot_ctrl;
  localparam int DW = 16;
  localparam int AW = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_req = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic [CW-1:0] run_limit = '0;
  logic          halt_req = 1'b0;
  logic [AW-1:0] cpu_i_addr = '0;
  logic [AW-1:0] im_addr;
  logic          im_we;
  logic [DW-1:0] im_din;
  logic          cpu_reset, cpu_start, cpu_enable;
  logic [2:0]    state;
  logic [AW:0]   load_cnt;
  logic [CW-1:0] cycle_cnt;
  logic          ld_err;

  pipe_cpu_boot_ctrl #(.DATA_W(DW), .I_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .run_limit(run_limit), .halt_req(halt_req), .cpu_i_addr(cpu_i_addr),
    .im_addr(im_addr), .im_we(im_we), .im_din(im_din),
    .cpu_reset(cpu_reset), .cpu_start(cpu_start), .cpu_enable(cpu_enable),
    .state(state), .load_cnt(load_cnt), .cycle_cnt(cycle_cnt), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [CW-1:0] cyc; int en; } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  logic [DW-1:0] wd [0:7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected memory writes and end-of-run records.
  logic [2:0] prev_state = 3'd0;
  int         en_run = 0;
  always @(negedge clk) begin
    if (!rst && im_we) begin
      if (wr_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", im_addr, im_din);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_addr", 32'(im_addr), 32'(w.addr));
        chk("wr_data", 32'(im_din), 32'(w.data));
      end
    end
    if (cpu_enable) en_run++;
    if (state == 3'd0) en_run = 0;
    if (state == 3'd4 && prev_state != 3'd4) begin
      if (done_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done: cycle_cnt %0d, none expected", cycle_cnt);
      end else begin
        done_t d;
        d = done_q.pop_front();
        chk("done_cycle_cnt", 32'(cycle_cnt), 32'(d.cyc));
        chk("enable_cycles", 32'(en_run), 32'(d.en));
      end
      en_run = 0;
    end
    prev_state <= state;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_load();
    load_req = 1'b1; tick(); load_req = 1'b0;
    chk("load_state", 32'(state), 32'd1);
    chk("ld_ready_latency", 32'(ld_ready), 32'd1);
  endtask

  // Streams wd[0..n-1]; ld_last on the final word if with_last; gap cycles after word gap_idx.
  task automatic send_words(input int n, input bit with_last, input int gap_idx, input int gap);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1; ld_data = wd[i]; ld_last = with_last && (i == n - 1);
      wr_q.push_back('{addr: AW'(i), data: wd[i]});
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      if (i == gap_idx) repeat (gap) tick();
    end
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (state != 3'd4 && k < 100) begin tick(); k++; end
    if (state != 3'd4) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: state %0d expected 4", nm, state);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    // 1. reset
    rst = 1'b1; tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_enable", 32'(cpu_enable), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("rst_ld_err", 32'(ld_err), 32'd0);
    rst = 1'b0; tick();

    // 2./3. three-word load with a gap, limit 5
    wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333;
    run_limit = 16'd5;
    done_q.push_back('{cyc: 16'd5, en: 6});
    start_load();
    send_words(3, 1'b1, 1, 2);
    chk("start_state", 32'(state), 32'd2);
    chk("start_pulse", 32'(cpu_start), 32'd1);
    chk("load_cnt3", 32'(load_cnt), 32'd3);
    tick();
    chk("run_state", 32'(state), 32'd3);
    chk("start_one_cycle", 32'(cpu_start), 32'd0);
    cpu_i_addr = 2'd3; #1;
    chk("run_im_addr", 32'(im_addr), 32'd3);
    wait_done("lim5");
    chk("done_enable", 32'(cpu_enable), 32'd0);
    chk("done_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("done_cycle_cnt5", 32'(cycle_cnt), 32'd5);
    tick();
    chk("done_hold", 32'(state), 32'd4);

    // 4a. unlimited, halt in RUN cycle 10
    wd[0] = 16'hAAAA; run_limit = 16'd0;
    done_q.push_back('{cyc: 16'd10, en: 11});
    start_load();
    send_words(1, 1'b1, -1, 0);
    tick();                       // RUN cycle 1
    repeat (9) tick();            // RUN cycle 10
    chk("halt_pre_state", 32'(state), 32'd3);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("halt_done", 32'(state), 32'd4);
    chk("halt_cycle_cnt", 32'(cycle_cnt), 32'd10);

    // 4b. limit 10 and halt in the same cycle
    wd[0] = 16'hBBBB; run_limit = 16'd10;
    done_q.push_back('{cyc: 16'd10, en: 11});
    start_load();
    send_words(1, 1'b1, -1, 0);
    tick();
    repeat (9) tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("both_done", 32'(state), 32'd4);
    chk("both_cycle_cnt", 32'(cycle_cnt), 32'd10);
    tick();
    chk("both_hold", 32'(state), 32'd4);

    // 5. overflow: four words without ld_last into a 4-deep memory
    wd[0] = 16'h0A00; wd[1] = 16'h0A01; wd[2] = 16'h0A02; wd[3] = 16'h0A03;
    start_load();
    send_words(4, 1'b0, -1, 0);
    chk("ovf_state", 32'(state), 32'd0);
    chk("ovf_err", 32'(ld_err), 32'd1);
    chk("ovf_load_cnt", 32'(load_cnt), 32'd4);
    ld_valid = 1'b1; ld_data = 16'h0A04; #1;
    chk("ovf_ready", 32'(ld_ready), 32'd0);
    chk("ovf_no_we", 32'(im_we), 32'd0);
    tick(); ld_valid = 1'b0;
    chk("err_sticky", 32'(ld_err), 32'd1);
    start_load();
    chk("err_cleared", 32'(ld_err), 32'd0);

    // full-depth image ending exactly at the last address; load_req during RUN
    wd[0] = 16'hC000; wd[1] = 16'hC001; wd[2] = 16'hC002; wd[3] = 16'hC003;
    run_limit = 16'd4;
    done_q.push_back('{cyc: 16'd4, en: 5});
    send_words(4, 1'b1, -1, 0);
    chk("full_start", 32'(state), 32'd2);
    chk("full_no_err", 32'(ld_err), 32'd0);
    chk("full_load_cnt", 32'(load_cnt), 32'd4);
    tick(); tick();               // RUN cycle 2
    load_req = 1'b1; tick(); load_req = 1'b0;
    chk("ldreq_ignored", 32'(state), 32'd3);
    wait_done("lim4");
    chk("lim4_load_cnt", 32'(load_cnt), 32'd4);

    // 6. reset during RUN cycle 3
    wd[0] = 16'hD000; run_limit = 16'd0;
    start_load();
    send_words(1, 1'b1, -1, 0);
    tick(); tick(); tick();       // RUN cycle 3
    chk("pre_rst_run", 32'(state), 32'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrun_rst_state", 32'(state), 32'd0);
    chk("midrun_rst_cnt", 32'(cycle_cnt), 32'd0);
    chk("midrun_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    tick(); tick();

    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_cpu_boot_ctrl.md
Name: pipe_cpu_boot_ctrl

Overview:
Boot and run controller that sits between the pipelined CPU core and its instruction memory. It streams a program image into instruction memory over a valid/ready word interface. It then releases CPU reset and pulses start, and runs the CPU for a programmable cycle budget or until halted. After a run, the CPU is frozen so its state stays observable through the select/y debug path.

Parameters:
DATA_W, 16, instruction word width
I_ADDR_W, 8, instruction memory address width; depth = 2^I_ADDR_W words
CNT_W, 16, width of the run-cycle counter and of run_limit

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
load_req  in  1  request a new program load (honoured in IDLE and DONE only)
ld_valid  in  1  load word valid
ld_data  in  DATA_W  load word
ld_last  in  1  marks final word of image, qualified by ld_valid
ld_ready  out  1  controller accepts a load word
run_limit  in  CNT_W  RUN cycle budget, sampled in START; 0 = unlimited
halt_req  in  1  stop the CPU (RUN only)
cpu_i_addr  in  I_ADDR_W  CPU instruction fetch address
im_addr  out  I_ADDR_W  instruction memory address
im_we  out  1  instruction memory write enable
im_din  out  DATA_W  instruction memory write data
cpu_reset  out  1  CPU reset
cpu_start  out  1  CPU start pulse
cpu_enable  out  1  CPU clock enable
state  out  3  FSM state: IDLE=0, LOAD=1, START=2, RUN=3, DONE=4
load_cnt  out  I_ADDR_W+1  words written in the last load
cycle_cnt  out  CNT_W  RUN cycles executed
ld_err  out  1  sticky: image overflowed memory depth

Behaviour:
- Single clock domain.
- rst is sampled on clk; no asynchronous paths.
- On rst, on the next edge:
  - state=IDLE
  - load pointer, load_cnt and cycle_cnt = 0
  - ld_err = 0
  - stored limit = 0
- cpu_reset, cpu_start, cpu_enable and ld_ready are Moore decodes of state:
  - IDLE: reset=1, start=0, enable=0, ready=0
  - LOAD: reset=1, start=0, enable=0, ready=1
  - START: reset=0, start=1, enable=1, ready=0
  - RUN: reset=0, start=0, enable=1, ready=0
  - DONE: reset=0, start=0, enable=0, ready=0
- im_addr:
  - IDLE and LOAD: im_addr = load pointer.
  - All other states: im_addr = cpu_i_addr.
- im_we:
  - im_we = ld_valid & ld_ready, combinational, with im_din = ld_data.
  - im_we is 0 outside LOAD.
- IDLE:
  - load_req -> LOAD.
  - On this transition, clear pointer, load_cnt and ld_err.
- LOAD:
  - Each accepted word writes at the pointer, then pointer++ and load_cnt++.
  - ld_valid low holds the state; gaps of any length are allowed.
  - Accepted word with ld_last=1 -> START.
  - Accepted word at address 2^I_ADDR_W-1 with ld_last=0 -> ld_err=1, go to IDLE. That word is written; no further words are accepted.
  - Accepted word at address 2^I_ADDR_W-1 with ld_last=1 -> START, no error.
- START:
  - Lasts exactly one cycle.
  - Latches run_limit and clears cycle_cnt.
  - -> RUN.
- RUN:
  - cycle_cnt increments every RUN cycle, including the exit cycle.
  - cycle_cnt saturates at 2^CNT_W-1.
  - Exits to DONE when halt_req=1, or when the limit is non-zero and cycle_cnt == limit-1 in that cycle.
  - Both exit conditions in the same cycle -> single transition to DONE.
  - With limit L, cpu_enable is high for exactly 1+L cycles (START + L RUN cycles), and DONE shows cycle_cnt = L.
- DONE:
  - Holds cycle_cnt and load_cnt.
  - load_req -> LOAD, which reloads the image and clears cycle_cnt on the next START.
- Ignored inputs:
  - load_req in LOAD/START/RUN.
  - halt_req outside RUN.
  - ld_valid outside LOAD.
- Reset mid-LOAD or mid-RUN:
  - Immediate return to IDLE on that edge.
  - Any partial image is abandoned.
  - cpu_reset reasserts in the following cycle.
- Latency:
  - load_req to ld_ready high: 1 cycle.
  - Last-word acceptance to cpu_start: 1 cycle.

Test Plan:
1. Hold rst for 2 cycles -> state=0, cpu_reset=1, cpu_enable=0, ld_ready=0, cycle_cnt=0, ld_err=0.
2. load_req, then words 0x1111, 0x2222, 0x3333 with a 2-cycle ld_valid gap and ld_last on the third -> im_we pulses at im_addr 0, 1, 2 with matching data; load_cnt=3; cpu_start high for exactly one cycle; state=RUN.
3. run_limit=5 -> cpu_enable high for 6 consecutive cycles; state=DONE with cycle_cnt=5; cpu_enable=0; cpu_reset=0.
4. run_limit=0 and halt_req asserted in the 10th RUN cycle -> DONE with cycle_cnt=10. Repeat with run_limit=10 plus halt in the same cycle -> single DONE, cycle_cnt=10.
5. I_ADDR_W=2, five words streamed without ld_last -> writes at 0..3, ld_err=1 after the 4th, state=IDLE, 5th word not accepted (ld_ready=0). A new load_req clears ld_err.
6. rst asserted in RUN cycle 3 -> next edge state=IDLE, cycle_cnt=0, cpu_reset=1. A separate check: load_req pulsed during RUN leaves the run unaffected.
